// File: rtl/forward_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Shadows in-flight destination registers and registers the EX operand-mux selects.
module forward_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             ex_valid,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned REG_W = 5;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
  } stage_t;

  localparam stage_t BUBBLE = '{valid: 1'b0, rd: '0, reg_write: 1'b0, mem_read: 1'b0};

  // The MEM/WB occupant needs no tracking: its value reaches ID through the
  // register file's write-before-read, so only ID/EX and EX/MEM are shadowed.
  stage_t s_ex;
  stage_t s_mem;

  logic hazard;

  function automatic logic produces(input stage_t s, input logic [REG_W-1:0] r);
    return s.valid & s.reg_write & (s.rd == r) & (r != REG_W'(0));
  endfunction

  // Nearer stage wins: what is in ID/EX now sits in EX/MEM during the consumer's EX.
  function automatic logic [1:0] sel_for(input stage_t ex, input stage_t mem,
                                          input logic [REG_W-1:0] r);
    if (produces(ex, r))       return SEL_MEM;
    else if (produces(mem, r)) return SEL_WB;
    else                       return SEL_RF;
  endfunction

  always_comb begin
    hazard = id_valid & s_ex.valid & s_ex.mem_read & s_ex.reg_write &
             (s_ex.rd != REG_W'(0)) & ((s_ex.rd == id_rs1) | (s_ex.rd == id_rs2));
    stall  = hazard & ~flush;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ex      <= BUBBLE;
      s_mem     <= BUBBLE;
      fwd_a_sel <= SEL_RF;
      fwd_b_sel <= SEL_RF;
      stall_cnt <= '0;
    end else begin
      s_mem <= s_ex;
      if (flush || stall) begin
        s_ex      <= BUBBLE;
        fwd_a_sel <= SEL_RF;
        fwd_b_sel <= SEL_RF;
      end else begin
        s_ex <= '{valid: id_valid, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};
        if (id_valid) begin
          fwd_a_sel <= sel_for(s_ex, s_mem, id_rs1);
          fwd_b_sel <= sel_for(s_ex, s_mem, id_rs2);
        end else begin
          fwd_a_sel <= SEL_RF;
          fwd_b_sel <= SEL_RF;
        end
      end
      if (stall && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign ex_valid = s_ex.valid;

endmodule

// File: tb/tb_forward_ctrl.sv
// Directed bench for forward_ctrl: forwarding selects, load-use stall, flush, reset, saturation.
module tb_forward_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic        id_reg_write = 1'b0, id_mem_read = 1'b0, flush = 1'b0;

  logic        stall, ex_valid;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_cnt;

  logic        stall2, ex_valid2;
  logic [1:0]  fwd_a_sel2, fwd_b_sel2;
  logic [1:0]  stall_cnt2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  forward_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .stall(stall), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .ex_valid(ex_valid),
    .stall_cnt(stall_cnt)
  );

  forward_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .stall(stall2), .fwd_a_sel(fwd_a_sel2), .fwd_b_sel(fwd_b_sel2), .ex_valid(ex_valid2),
    .stall_cnt(stall_cnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rw, input logic mr);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_reg_write = rw; id_mem_read = mr;
    #1;
  endtask

  task automatic drain();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    #2;
    tests++; if (fwd_a_sel !== 2'b00) begin fails++; $display("FAIL reset_fwd_a got=%b exp=00", fwd_a_sel); end
    tests++; if (fwd_b_sel !== 2'b00) begin fails++; $display("FAIL reset_fwd_b got=%b exp=00", fwd_b_sel); end
    tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL reset_ex_valid got=%b exp=0", ex_valid); end
    tests++; if (stall_cnt !== 16'd0) begin fails++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got=%b exp=0", stall); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);   // add x5
    tick();
    drive(1'b1, 5'd5, 5'd3, 5'd8, 1'b1, 1'b0);   // sub x8, x5, x3
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL b2b_stall got=%b exp=0", stall); end
    tick();
    tests++; if (fwd_a_sel !== 2'b01) begin fails++; $display("FAIL b2b_fwd_a got=%b exp=01", fwd_a_sel); end
    tests++; if (fwd_b_sel !== 2'b00) begin fails++; $display("FAIL b2b_fwd_b got=%b exp=00", fwd_b_sel); end
    tests++; if (ex_valid !== 1'b1) begin fails++; $display("FAIL b2b_ex_valid got=%b exp=1", ex_valid); end
    drain();
  endtask

  task automatic test_distance2();
    drive(1'b1, 5'd1, 5'd2, 5'd6, 1'b1, 1'b0);   // add x6
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);   // nop
    tick();
    drive(1'b1, 5'd1, 5'd6, 5'd9, 1'b1, 1'b0);
    tick();
    tests++; if (fwd_b_sel !== 2'b10) begin fails++; $display("FAIL dist2_fwd_b got=%b exp=10", fwd_b_sel); end
    tests++; if (fwd_a_sel !== 2'b00) begin fails++; $display("FAIL dist2_fwd_a got=%b exp=00", fwd_a_sel); end
    drain();
    drive(1'b1, 5'd1, 5'd2, 5'd6, 1'b1, 1'b0);   // add x6 (distance 2)
    tick();
    drive(1'b1, 5'd3, 5'd4, 5'd6, 1'b1, 1'b0);   // add x6 (distance 1)
    tick();
    drive(1'b1, 5'd6, 5'd6, 5'd9, 1'b1, 1'b0);   // rs1 == rs2 == x6
    tick();
    tests++; if (fwd_b_sel !== 2'b01) begin fails++; $display("FAIL nearer_wins_fwd_b got=%b exp=01", fwd_b_sel); end
    tests++; if (fwd_a_sel !== 2'b01) begin fails++; $display("FAIL same_src_fwd_a got=%b exp=01", fwd_a_sel); end
    drain();
  endtask

  task automatic test_load_use();
    drive(1'b1, 5'd2, 5'd0, 5'd7, 1'b1, 1'b1);   // lw x7
    tick();
    drive(1'b1, 5'd7, 5'd3, 5'd10, 1'b1, 1'b0);  // add x10, x7, x3
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL lu_stall got=%b exp=1", stall); end
    tick();
    tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL lu_bubble got=%b exp=0", ex_valid); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL lu_no_restall got=%b exp=0", stall); end
    tests++; if (stall_cnt !== 16'd1) begin fails++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); end
    tick();
    tests++; if (ex_valid !== 1'b1) begin fails++; $display("FAIL lu_ex_valid got=%b exp=1", ex_valid); end
    tests++; if (fwd_a_sel !== 2'b10) begin fails++; $display("FAIL lu_fwd_a got=%b exp=10", fwd_a_sel); end
    tests++; if (fwd_b_sel !== 2'b00) begin fails++; $display("FAIL lu_fwd_b got=%b exp=00", fwd_b_sel); end
    tests++; if (stall_cnt !== 16'd1) begin fails++; $display("FAIL lu_cnt_hold got=%0d exp=1", stall_cnt); end
    drain();
  endtask

  task automatic test_x0();
    drive(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1);   // lw x0
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL x0_stall got=%b exp=0", stall); end
    tick();
    tests++; if (fwd_a_sel !== 2'b00) begin fails++; $display("FAIL x0_fwd_a got=%b exp=00", fwd_a_sel); end
    tests++; if (fwd_b_sel !== 2'b00) begin fails++; $display("FAIL x0_fwd_b got=%b exp=00", fwd_b_sel); end
    drain();
    drive(1'b1, 5'd1, 5'd2, 5'd11, 1'b0, 1'b0);  // store-like, no rd write
    tick();
    drive(1'b1, 5'd11, 5'd11, 5'd9, 1'b1, 1'b0);
    tick();
    tests++; if (fwd_a_sel !== 2'b00) begin fails++; $display("FAIL nowrite_fwd_a got=%b exp=00", fwd_a_sel); end
    drain();
  endtask

  task automatic test_flush();
    drive(1'b1, 5'd2, 5'd0, 5'd12, 1'b1, 1'b1);  // lw x12
    tick();
    drive(1'b1, 5'd12, 5'd3, 5'd9, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL flush_stall got=%b exp=0", stall); end
    tick();
    flush = 1'b0;
    tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL flush_bubble got=%b exp=0", ex_valid); end
    tests++; if (stall_cnt !== 16'd1) begin fails++; $display("FAIL flush_cnt got=%0d exp=1", stall_cnt); end
    drain();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 5'd2, 5'd0, 5'd13, 1'b1, 1'b1);  // lw x13
    tick();
    drive(1'b1, 5'd4, 5'd13, 5'd9, 1'b1, 1'b0);
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL rstmid_pre_stall got=%b exp=1", stall); end
    rst = 1'b1;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rstmid_stall got=%b exp=0", stall); end
    tests++; if (fwd_b_sel !== 2'b00) begin fails++; $display("FAIL rstmid_fwd_b got=%b exp=00", fwd_b_sel); end
    tests++; if (stall_cnt !== 16'd0) begin fails++; $display("FAIL rstmid_cnt got=%0d exp=0", stall_cnt); end
    tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL rstmid_ex_valid got=%b exp=0", ex_valid); end
    rst = 1'b0;
    #1;
    tick();
    tests++; if (fwd_b_sel !== 2'b00) begin fails++; $display("FAIL post_rst_fwd_b got=%b exp=00", fwd_b_sel); end
    tests++; if (ex_valid !== 1'b1) begin fails++; $display("FAIL post_rst_ex_valid got=%b exp=1", ex_valid); end
    drain();
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'd2, 5'd0, 5'd14, 1'b1, 1'b1);   // lw x14
      tick();
      drive(1'b1, 5'd14, 5'd3, 5'd15, 1'b1, 1'b0);  // consumer of x14
      tick();
      tick();
      if (i == 1) begin
        tests++; if (stall_cnt2 !== 2'd2) begin fails++; $display("FAIL sat_cnt_mid got=%0d exp=2", stall_cnt2); end
      end
    end
    tests++; if (stall_cnt2 !== 2'd3) begin fails++; $display("FAIL sat_cnt got=%0d exp=3", stall_cnt2); end
    tests++; if (stall_cnt !== 16'd5) begin fails++; $display("FAIL wide_cnt got=%0d exp=5", stall_cnt); end
    tests++; if (fwd_a_sel2 !== 2'b10) begin fails++; $display("FAIL sat_fwd_a got=%b exp=10", fwd_a_sel2); end
    drain();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_distance2();
    test_load_use();
    test_x0();
    test_flush();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
